// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster types, default 800x480 timing and sizing helpers
package video_timing_pkg;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    // Wide enough for any practical geometry; outputs are narrowed to XW/YW at the top.
    localparam int POS_W = 16;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } raster_pos_t;

    function automatic int calc_total(input int disp, input int fp, input int pulse, input int bp);
        return disp + fp + pulse + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster output bundle driven by the timing generator
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int XW = cnt_width(calc_total(DEF_HDISP, DEF_HFP, DEF_HPULSE, DEF_HBP)),
    parameter int YW = cnt_width(calc_total(DEF_VDISP, DEF_VFP, DEF_VPULSE, DEF_VBP))
);
    logic          hs;
    logic          vs;
    logic          blank_n;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sol;
    logic          sof;
    logic          req;
    logic [15:0]   frame_cnt;

    modport master (output hs, vs, blank_n, x, y, sol, sof, req, frame_cnt);
    modport slave  (input  hs, vs, blank_n, x, y, sol, sof, req, frame_cnt);
endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - wrapping 2-D raster position counter with enable and configurable reset position
module raster_counter
    import video_timing_pkg::*;
#(
    parameter int HTOTAL = 14,
    parameter int VTOTAL = 7,
    parameter int RST_X  = 0,
    parameter int RST_Y  = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_i,
    output raster_pos_t pos_o
);
    raster_pos_t pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (en_i) begin
            if (pos_q.x == POS_W'(HTOTAL - 1)) begin
                pos_d.x = '0;
                pos_d.y = (pos_q.y == POS_W'(VTOTAL - 1)) ? '0 : pos_q.y + POS_W'(1);
            end else begin
                pos_d.x = pos_q.x + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pos_q.x <= POS_W'(RST_X);
            pos_q.y <= POS_W'(RST_Y);
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;
endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: sync/blank decode, coordinates, strobes and prefetch request
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int HDISP     = DEF_HDISP,
    parameter int VDISP     = DEF_VDISP,
    parameter int HFP       = DEF_HFP,
    parameter int HPULSE    = DEF_HPULSE,
    parameter int HBP       = DEF_HBP,
    parameter int VFP       = DEF_VFP,
    parameter int VPULSE    = DEF_VPULSE,
    parameter int VBP       = DEF_VBP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOOKAHEAD = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    video_timing_gen_if.master vid
);
    localparam int HTOTAL = calc_total(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = calc_total(VDISP, VFP, VPULSE, VBP);
    localparam int XW     = cnt_width(HTOTAL);
    localparam int YW     = cnt_width(VTOTAL);
    // The lookahead counter starts LOOKAHEAD positions ahead so req leads blank_n by exactly that much.
    localparam int LA_X   = LOOKAHEAD % HTOTAL;
    localparam int LA_Y   = (LOOKAHEAD / HTOTAL) % VTOTAL;

    raster_pos_t main_pos, la_pos;

    raster_counter #(.HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .RST_X(0), .RST_Y(0)) u_main (
        .clk(clk), .nrst(nrst), .en_i(en), .pos_o(main_pos)
    );

    raster_counter #(.HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .RST_X(LA_X), .RST_Y(LA_Y)) u_la (
        .clk(clk), .nrst(nrst), .en_i(en), .pos_o(la_pos)
    );

    logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic          sol_q, sol_d, sof_q, sof_d, req_q, req_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          in_hs, in_vs, frame_wrap;

    always_comb begin
        in_hs = (main_pos.x >= POS_W'(HDISP + HFP)) && (main_pos.x < POS_W'(HDISP + HFP + HPULSE));
        in_vs = (main_pos.y >= POS_W'(VDISP + VFP)) && (main_pos.y < POS_W'(VDISP + VFP + VPULSE));
        frame_wrap = (main_pos.x == POS_W'(HTOTAL - 1)) && (main_pos.y == POS_W'(VTOTAL - 1));

        hs_d        = in_hs ? HS_POL : ~HS_POL;
        vs_d        = in_vs ? VS_POL : ~VS_POL;
        blank_n_d   = (main_pos.x < POS_W'(HDISP)) && (main_pos.y < POS_W'(VDISP));
        req_d       = (la_pos.x < POS_W'(HDISP)) && (la_pos.y < POS_W'(VDISP));
        sol_d       = (main_pos.x == '0) && (main_pos.y < POS_W'(VDISP));
        sof_d       = (main_pos.x == '0) && (main_pos.y == '0);
        x_d         = main_pos.x[XW-1:0];
        y_d         = main_pos.y[YW-1:0];
        frame_cnt_d = frame_cnt_q + 16'(frame_wrap);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            blank_n_q   <= 1'b0;
            req_q       <= 1'b0;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
        end else if (en) begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            req_q       <= req_d;
            sol_q       <= sol_d;
            sof_q       <= sof_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vid.hs        = hs_q;
    assign vid.vs        = vs_q;
    assign vid.blank_n   = blank_n_q;
    assign vid.req       = req_q;
    assign vid.sol       = sol_q;
    assign vid.sof       = sof_q;
    assign vid.x         = x_q;
    assign vid.y         = y_q;
    assign vid.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a 14x7 raster
module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic [3:0]  x;
        logic [2:0]  y;
        logic        sol;
        logic        sof;
        logic        req;
        logic        req0;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic nrst;
    logic en;

    video_timing_gen_if #(.XW(4), .YW(3)) vid ();
    video_timing_gen_if #(.XW(4), .YW(3)) vid0 ();

    video_timing_gen #(
        .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(4)
    ) dut (.clk(clk), .nrst(nrst), .en(en), .vid(vid));

    video_timing_gen #(
        .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(0)
    ) dut0 (.clk(clk), .nrst(nrst), .en(en), .vid(vid0));

    int   checks = 0;
    int   errors = 0;
    int   k      = 0;
    int   fc_m   = 0;
    exp_t cur;
    exp_t me;
    exp_t exp_q[$];
    int   n_blank, n_sol, n_sof, n_vs_low, n_hs_low, n_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (pos %0d)", name, act, expv, k);
        end
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Hand-decoded 14x7 raster: active x<8,y<4; hs low x=10..11; vs low on line 5.
    function automatic exp_t model(input int pos, input int fc);
        exp_t e;
        int   hc, vc, lk;
        hc        = pos % 14;
        vc        = pos / 14;
        lk        = (pos + 4) % 98;
        e.blank_n = (hc < 8) && (vc < 4);
        e.hs      = !(hc == 10 || hc == 11);
        e.vs      = (vc != 5);
        e.x       = 4'(hc);
        e.y       = 3'(vc);
        e.sol     = (hc == 0) && (vc < 4);
        e.sof     = (pos == 0);
        e.req     = ((lk % 14) < 8) && ((lk / 14) < 4);
        e.req0    = e.blank_n;
        e.fc      = 16'(fc);
        return e;
    endfunction

    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            if (k == 97) fc_m = (fc_m + 1) % 65536;
            cur = model(k, fc_m);
            k   = (k + 1) % 98;
        end
        exp_q.push_back(cur);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk("async_rst_x", vid.x, 0);
        chk("async_rst_blank_n", vid.blank_n, 0);
        chk("async_rst_hs", vid.hs, 1);
        chk("async_rst_frame_cnt", vid.frame_cnt, 0);
        k    = 0;
        fc_m = 0;
        cur  = rst_exp();
        @(posedge clk);
        #1;
        exp_q.push_back(cur);
        nrst = 1'b1;
    endtask

    task automatic clear_counts();
        n_blank = 0; n_sol = 0; n_sof = 0; n_vs_low = 0; n_hs_low = 0; n_req = 0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("hs", vid.hs, me.hs);
            chk("vs", vid.vs, me.vs);
            chk("blank_n", vid.blank_n, me.blank_n);
            chk("x", vid.x, me.x);
            chk("y", vid.y, me.y);
            chk("sol", vid.sol, me.sol);
            chk("sof", vid.sof, me.sof);
            chk("req", vid.req, me.req);
            chk("frame_cnt", vid.frame_cnt, me.fc);
            chk("req_la0", vid0.req, me.req0);
            chk("blank_n_la0", vid0.blank_n, me.blank_n);
            if (vid.blank_n) n_blank++;
            if (vid.sol) n_sol++;
            if (vid.sof) n_sof++;
            if (!vid.vs) n_vs_low++;
            if (!vid.hs) n_hs_low++;
            if (vid.req) n_req++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b1;
        en   = 1'b0;
        cur  = rst_exp();
        apply_reset();

        clear_counts();
        repeat (98) step(1'b1);
        chk("fc_edge98", vid.frame_cnt, 1);
        @(negedge clk);
        #1;
        chk("frame_active_cycles", n_blank, 32);
        chk("frame_sol_count", n_sol, 4);
        chk("frame_sof_count", n_sof, 1);
        chk("frame_vs_low_cycles", n_vs_low, 14);
        chk("frame_hs_low_cycles", n_hs_low, 14);
        chk("frame_req_cycles", n_req, 32);

        clear_counts();
        for (int i = 1; i <= 196; i++) begin
            step(1'b1);
            if (i == 98) chk("fc_edge196", vid.frame_cnt, 2);
        end
        chk("fc_edge294", vid.frame_cnt, 3);
        @(negedge clk);
        #1;
        chk("two_frame_sof_count", n_sof, 2);
        chk("two_frame_sol_count", n_sol, 8);

        repeat (4) step(1'b1);
        chk("x_before_freeze", vid.x, 3);
        repeat (5) step(1'b0);
        chk("x_frozen", vid.x, 3);
        step(1'b1);
        chk("x_resume", vid.x, 4);
        repeat (92) step(1'b1);
        chk("fc_stretched_edge102", vid.frame_cnt, 3);
        step(1'b1);
        chk("fc_stretched_edge103", vid.frame_cnt, 4);

        repeat (34) step(1'b1);
        chk("x_pre_reset", vid.x, 5);
        chk("y_pre_reset", vid.y, 2);
        apply_reset();
        repeat (2) step(1'b0);
        step(1'b1);
        chk("sof_after_reset", vid.sof, 1);
        chk("fc_after_reset", vid.frame_cnt, 0);
        repeat (97) step(1'b1);
        chk("fc_after_reset_frame", vid.frame_cnt, 1);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the video controller: produces HS, VS and active-low blank for any display geometry, plus pixel coordinates, line/frame strobes, a frame counter and a pixel prefetch request issued a configurable number of cycles ahead of active video. It sits between the pixel clock domain and the `video_if` master port of `Top`. It also feeds the framebuffer read FIFO, which needs lookahead to hide memory latency.

## Interface

- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `HFP`, 40, horizontal front porch (cycles)
- `HPULSE`, 48, horizontal sync width (cycles)
- `HBP`, 40, horizontal back porch (cycles)
- `VFP`, 13, vertical front porch (lines)
- `VPULSE`, 3, vertical sync width (lines)
- `VBP`, 29, vertical back porch (lines)
- `HS_POL`, 0, HS active level (1 = active high)
- `VS_POL`, 0, VS active level
- `LOOKAHEAD`, 4, cycles `req` leads `blank_n`; legal range 0..HFP+HPULSE+HBP
- `clk`  in  1  pixel clock, single clock domain
- `nrst`  in  1  reset, asynchronous, active low
- `en`  in  1  advance enable; 0 freezes the raster
- `hs`  out  1  horizontal sync
- `vs`  out  1  vertical sync
- `blank_n`  out  1  1 during active video
- `x`  out  XW  horizontal counter of current output, XW = $clog2(HTOTAL)
- `y`  out  YW  vertical counter of current output, YW = $clog2(VTOTAL)
- `sol`  out  1  start-of-active-line pulse
- `sof`  out  1  start-of-frame pulse
- `req`  out  1  pixel prefetch request
- `frame_cnt`  out  16  completed frames

## Operation

- HTOTAL = HDISP+HFP+HPULSE+HBP.
- VTOTAL = VDISP+VFP+VPULSE+VBP.
- Raster order per line: active, front porch, sync, back porch. Same order for lines within a frame.
- Main position (hc,vc), reset (0,0), advances when `en`=1.
  - hc wraps HTOTAL-1→0 and then vc increments.
  - vc wraps VTOTAL-1→0.
- Lookahead position: identical counter, reset to the raster position LOOKAHEAD steps after (0,0), with wrap applied. Advances under the same `en`. LOOKAHEAD=0 makes `req` ≡ `blank_n`.
- Decoded from the main position:
  - active = hc<HDISP && vc<VDISP
  - hs active for hc in [HDISP+HFP, HDISP+HFP+HPULSE-1], all lines
  - vs active for whole lines vc in [VDISP+VFP, VDISP+VFP+VPULSE-1], edges aligned to hc=0
  - sol = hc==0 && vc<VDISP
  - sof = hc==0 && vc==0
- `req` = active decoded from the lookahead position.
- `frame_cnt` increments when the main position wraps (HTOTAL-1,VTOTAL-1)→(0,0). Wraps 0xFFFF→0.
- `x`/`y` are raw counters and exceed HDISP/VDISP during blanking.
- `en`=0: counters, all outputs and frame_cnt hold their values; strobes held high stay high. Resuming continues seamlessly.

## Timing

- All outputs are registered from the decode of the current position, so the output for position k = vc·HTOTAL+hc is visible after edge k+1 (1-cycle latency).
- Reset values (immediate on `nrst`=0): hs=~HS_POL, vs=~VS_POL, blank_n=0, x=0, y=0, sol=0, sof=0, req=0, frame_cnt=0, counters at reset positions.
- First enabled edge after reset: blank_n=1, sof=1, sol=1, x=0, y=0.
- `req` rises exactly LOOKAHEAD enabled cycles before every `blank_n` rise and falls LOOKAHEAD cycles before every fall, including across line and frame wraps.
- `nrst` asserted mid-line: everything returns to reset values asynchronously; the next frame starts cleanly.

## Structure

- Package `video_timing_pkg`:
  - `raster_pos_t` typedef (x/y fields, parametrised widths via localparam helpers)
  - HTOTAL/VTOTAL computation function
  - default 800×480 timing constants
- Sub-module `raster_counter`:
  - wrapping 2-D counter with `en`
  - parameters: totals, reset position
  - instanced twice (main, lookahead)
- Top level holds the decode and output registers.

## Test plan

Bench parameters for all scenarios: HDISP=8, VDISP=4, HFP=2, HPULSE=2, HBP=2, VFP=1, VPULSE=1, VBP=1, giving HTOTAL=14, VTOTAL=7, 98 cycles/frame.

- Reset, then `en`=1 for 98 cycles:
  - blank_n high 8 of every 14 cycles on the first 4 lines only; 32 active cycles total
  - hs (HS_POL=0) low at x=10,11
  - vs low for line y=5 (14 cycles)
- LOOKAHEAD=4: `req` rises 4 cycles before each blank_n rise, including the (13,6)→(0,0) wrap; `req` first high at edges 1..4 of line y=3's successor region. LOOKAHEAD=0: req==blank_n every cycle.
- Run 3 frames: frame_cnt 0→1→2→3 at edges 98, 196, 294; sof pulses once per frame, sol 4 times per frame.
- Toggle `en` low for 5 cycles at x=3: all outputs frozen, then resume at x=4 with no skipped or duplicated position; frame length becomes 103 cycles.
- Assert `nrst` at x=5,y=2: all outputs take reset values immediately; after release, sof at the first enabled edge and frame_cnt=0.
